// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the 5-stage RV32 hazard controller.
// Forward-mux encodings, stall FSM states and a forward-select helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE,
      LD_STALL,
      MC_BUSY
   } hzd_state_e;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   // M is the younger producer, so it wins over W.
   function automatic fwd_sel_e fwd_pick(
      input logic hit_m,
      input logic hit_w
   );
      if (hit_m) return FWD_MEM;
      if (hit_w) return FWD_WB;
      return FWD_NONE;
   endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// hazard_ctrl_mc_if: datapath <-> hazard controller bundle.
// master = datapath (drives stage regs/flags), slave = hazard controller
// (drives forward_a/b, stall_f/d/e, flush_d/e, mc_timeout).
interface hazard_ctrl_mc_if #(
   parameter int REG_AW = 5
);
   import hazard_pkg::*;

   logic [REG_AW-1:0] rs1_d;
   logic [REG_AW-1:0] rs2_d;
   logic [REG_AW-1:0] rs1_e;
   logic [REG_AW-1:0] rs2_e;
   logic [REG_AW-1:0] rd_e;
   logic [REG_AW-1:0] rd_m;
   logic [REG_AW-1:0] rd_w;
   logic [REG_AW-1:0] mc_rd;
   logic              reg_wr_m;
   logic              reg_wr_w;
   logic              mem_rd_e;
   logic              branch_taken_e;
   logic              mc_op_d;
   logic              mc_start_e;
   logic              mc_done;

   fwd_sel_e          forward_a;
   fwd_sel_e          forward_b;
   logic              stall_f;
   logic              stall_d;
   logic              stall_e;
   logic              flush_d;
   logic              flush_e;
   logic              mc_timeout;

   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e,
      output rd_e, rd_m, rd_w, mc_rd,
      output reg_wr_m, reg_wr_w, mem_rd_e,
      output branch_taken_e, mc_op_d,
      output mc_start_e, mc_done,
      input  forward_a, forward_b,
      input  stall_f, stall_d, stall_e,
      input  flush_d, flush_e, mc_timeout
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e,
      input  rd_e, rd_m, rd_w, mc_rd,
      input  reg_wr_m, reg_wr_w, mem_rd_e,
      input  branch_taken_e, mc_op_d,
      input  mc_start_e, mc_done,
      output forward_a, forward_b,
      output stall_f, stall_d, stall_e,
      output flush_d, flush_e, mc_timeout
   );

endinterface

// File: rtl/hzd_scoreboard.sv
// hzd_scoreboard: 1-entry {valid,rd} tracker for the in-flight mc op.
// Ports: clk, rst, set_i/rd_i (issue), clr_i (retire), rs1_i/rs2_i/mc_op_i
// (D-stage probe), stall_o (RAW or structural hazard). Built with HZD_SCOREBOARD_EN.
`ifdef HZD_SCOREBOARD_EN
module hzd_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_i,
   input  logic              clr_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic              mc_op_i,
   output logic              stall_o
);

   logic              valid_q;
   logic [REG_AW-1:0] rd_q;
   logic              raw;

   // A new issue in the retire cycle replaces the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
      end else if (set_i) begin
         valid_q <= 1'b1;
         rd_q    <= rd_i;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end
   end

   assign raw = (rd_q != '0) &&
                ((rs1_i == rd_q) || (rs2_i == rd_q));

   assign stall_o = valid_q && (raw || mc_op_i);

endmodule
`endif

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: stall/flush/forward control for the F/D/E/M/W pipe.
// Ports: clk, rst (sync, active-high), hz (slave: stage regs in,
// forward_a/b, stall_f/d/e, flush_d/e, mc_timeout out).
// Params: REG_AW, LOAD_LAT (1..3 load-use bubbles), MC_TO (mc watchdog).
// Macro HZD_SCOREBOARD_EN: mc ops stall only dependent D instructions.
module hazard_ctrl_mc
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MC_TO    = 64
) (
   input  logic            clk,
   input  logic            rst,
   hazard_ctrl_mc_if.slave hz
);

   localparam int             WDW     = $clog2(MC_TO + 1);
   localparam logic [1:0]     LD_INIT = 2'(LOAD_LAT - 1);
   localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(MC_TO - 1);

   hzd_state_e     state_q, state_d;
   logic [1:0]     ld_cnt_q, ld_cnt_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           tmo_q, tmo_d;

   logic st_f, st_d, st_e;
   logic fl_d, fl_e;
   logic load_use;
   logic mc_issue, mc_leave;
   logic a_m, a_w, b_m, b_w;

   assign a_m = hz.reg_wr_m && (hz.rs1_e != '0) &&
                (hz.rs1_e == hz.rd_m);
   assign a_w = hz.reg_wr_w && (hz.rs1_e != '0) &&
                (hz.rs1_e == hz.rd_w);
   assign b_m = hz.reg_wr_m && (hz.rs2_e != '0) &&
                (hz.rs2_e == hz.rd_m);
   assign b_w = hz.reg_wr_w && (hz.rs2_e != '0) &&
                (hz.rs2_e == hz.rd_w);

   assign load_use = hz.mem_rd_e && (hz.rd_e != '0) &&
                     ((hz.rd_e == hz.rs1_d) ||
                      (hz.rd_e == hz.rs2_d));

`ifdef HZD_SCOREBOARD_EN
   logic sb_stall;

   hzd_scoreboard #(
      .REG_AW (REG_AW)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_i   (mc_issue),
      .clr_i   (mc_leave),
      .rd_i    (hz.mc_rd),
      .rs1_i   (hz.rs1_d),
      .rs2_i   (hz.rs2_d),
      .mc_op_i (hz.mc_op_d),
      .stall_o (sb_stall)
   );
`else
   logic unused_sb;
   assign unused_sb = ^{hz.mc_op_d, hz.mc_rd,
                        mc_issue, mc_leave};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ld_cnt_q <= '0;
         wd_q     <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         wd_q     <= wd_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      wd_d     = wd_q;
      tmo_d    = tmo_q;
      st_f     = 1'b0;
      st_d     = 1'b0;
      st_e     = 1'b0;
      fl_d     = 1'b0;
      fl_e     = 1'b0;
      mc_issue = 1'b0;
      mc_leave = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Detection cycle is itself the first bubble.
            if (load_use) begin
               {st_f, st_d, fl_e} = 3'b111;
               if (LOAD_LAT > 1) begin
                  state_d  = LD_STALL;
                  ld_cnt_d = LD_INIT;
               end
            end else if (hz.mc_start_e &&
                         !hz.branch_taken_e) begin
               state_d  = MC_BUSY;
               wd_d     = WD_ONE;
               mc_issue = 1'b1;
            end
         end

         LD_STALL: begin
            {st_f, st_d, fl_e} = 3'b111;
            ld_cnt_d = ld_cnt_q - 2'd1;
            if (ld_cnt_q == 2'd1) begin
               state_d = IDLE;
            end
         end

         MC_BUSY: begin
`ifdef HZD_SCOREBOARD_EN
            if (load_use) begin
               {st_f, st_d, fl_e} = 3'b111;
            end
`else
            {st_f, st_d, st_e} = 3'b111;
`endif
            // wd_q counts cycles since issue, issue cycle = 0.
            if (hz.mc_done) begin
               if (hz.mc_start_e) begin
                  wd_d     = WD_ONE;
                  mc_issue = 1'b1;
               end else begin
                  state_d  = IDLE;
                  mc_leave = 1'b1;
               end
            end else if (wd_q == WD_LAST) begin
               state_d  = IDLE;
               tmo_d    = 1'b1;
               mc_leave = 1'b1;
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef HZD_SCOREBOARD_EN
      if (sb_stall) begin
         {st_f, st_d, fl_e} = 3'b111;
      end
`endif

      // Taken branch squashes younger work; an in-flight
      // mc op is older and keeps running.
      if (hz.branch_taken_e) begin
         {st_f, st_d, st_e} = 3'b000;
         {fl_d, fl_e}       = 2'b11;
         if (state_q != MC_BUSY) begin
            state_d = IDLE;
         end
      end
   end

   assign hz.forward_a  = rst ? FWD_NONE : fwd_pick(a_m, a_w);
   assign hz.forward_b  = rst ? FWD_NONE : fwd_pick(b_m, b_w);
   assign hz.stall_f    = st_f  & ~rst;
   assign hz.stall_d    = st_d  & ~rst;
   assign hz.stall_e    = st_e  & ~rst;
   assign hz.flush_d    = fl_d  & ~rst;
   assign hz.flush_e    = fl_e  & ~rst;
   assign hz.mc_timeout = tmo_q & ~rst;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed + random stimulus, queue scoreboard,
// monitor compares every cycle on the falling edge.
module tb_hazard_ctrl_mc;
   import hazard_pkg::*;

   localparam int AW   = 5;
   localparam int LLAT = 2;
   localparam int MTO  = 64;
`ifdef HZD_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   typedef struct packed {
      logic          rst;
      logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e;
      logic [AW-1:0] rd_e, rd_m, rd_w, mc_rd;
      logic          reg_wr_m, reg_wr_w, mem_rd_e;
      logic          br, mc_op_d, mc_start, mc_done;
   } stim_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic       sf, sd, se, fd, fe, tmo;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_mc_if #(.REG_AW(AW)) hz ();

   hazard_ctrl_mc #(
      .REG_AW   (AW),
      .LOAD_LAT (LLAT),
      .MC_TO    (MTO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // Reference state: bubbles still owed, in-flight mc op.
   int            m_ld_left = 0;
   bit            m_busy    = 0;
   int            m_issue   = 0;
   bit            m_tmo     = 0;
   logic [AW-1:0] m_sb_rd   = '0;

   function automatic logic [1:0] fwd(logic [AW-1:0] src, stim_t x);
      if (src != 0 && x.reg_wr_m && src == x.rd_m) return 2'b10;
      if (src != 0 && x.reg_wr_w && src == x.rd_w) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit is_lu(stim_t x);
      return x.mem_rd_e && x.rd_e != 0 &&
             (x.rd_e == x.rs1_d || x.rd_e == x.rs2_d);
   endfunction

   function automatic exp_t model_out(stim_t x);
      exp_t e = '0;
      bit   lu = is_lu(x);
      bit   dep;
      if (x.rst) return e;
      e.fa  = fwd(x.rs1_e, x);
      e.fb  = fwd(x.rs2_e, x);
      e.tmo = m_tmo;
      dep = (m_sb_rd != 0 &&
             (x.rs1_d == m_sb_rd || x.rs2_d == m_sb_rd)) || x.mc_op_d;
      if (m_ld_left > 0 || (lu && !m_busy)) begin
         e.sf = 1; e.sd = 1; e.fe = 1;
      end else if (m_busy) begin
         if (!SB_EN) begin
            e.sf = 1; e.sd = 1; e.se = 1;
         end else if (lu || dep) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
         end
      end
      if (x.br) begin
         e.sf = 0; e.sd = 0; e.se = 0;
         e.fd = 1; e.fe = 1;
      end
      return e;
   endfunction

   function automatic void model_next(stim_t x);
      if (x.rst) begin
         m_ld_left = 0; m_busy = 0; m_tmo = 0;
         return;
      end
      if (m_ld_left > 0) begin
         m_ld_left = x.br ? 0 : m_ld_left - 1;
      end else if (m_busy) begin
         if (x.mc_done) begin
            if (x.mc_start) begin
               m_issue = cyc; m_sb_rd = x.mc_rd;
            end else begin
               m_busy = 0;
            end
         end else if (cyc - m_issue >= MTO - 1) begin
            m_busy = 0; m_tmo = 1;
         end
      end else if (!x.br) begin
         if (is_lu(x)) begin
            m_ld_left = LLAT - 1;
         end else if (x.mc_start) begin
            m_busy = 1; m_issue = cyc; m_sb_rd = x.mc_rd;
         end
      end
   endfunction

   function automatic logic [AW-1:0] rreg();
      return AW'($urandom_range(0, 7));
   endfunction

   function automatic stim_t rnd();
      stim_t x = '0;
      x.rs1_d    = rreg();
      x.rs2_d    = rreg();
      x.rs1_e    = rreg();
      x.rs2_e    = rreg();
      x.rd_e     = rreg();
      x.rd_m     = rreg();
      x.rd_w     = rreg();
      x.mc_rd    = rreg();
      x.reg_wr_m = 1'($urandom_range(0, 1));
      x.reg_wr_w = 1'($urandom_range(0, 1));
      x.mem_rd_e = ($urandom_range(0, 3) == 0);
      x.br       = ($urandom_range(0, 11) == 0);
      x.mc_op_d  = ($urandom_range(0, 3) == 0);
      x.rst      = ($urandom_range(0, 249) == 0);
      if (m_busy) x.mc_done = ($urandom_range(0, 14) == 0);
      if (!x.br && !x.mem_rd_e &&
          (m_busy ? (SB_EN && x.mc_done) : (m_ld_left == 0)))
         x.mc_start = ($urandom_range(0, 7) == 0);
      return x;
   endfunction

   task automatic step(input stim_t x);
      rst               = x.rst;
      hz.rs1_d          = x.rs1_d;
      hz.rs2_d          = x.rs2_d;
      hz.rs1_e          = x.rs1_e;
      hz.rs2_e          = x.rs2_e;
      hz.rd_e           = x.rd_e;
      hz.rd_m           = x.rd_m;
      hz.rd_w           = x.rd_w;
      hz.mc_rd          = x.mc_rd;
      hz.reg_wr_m       = x.reg_wr_m;
      hz.reg_wr_w       = x.reg_wr_w;
      hz.mem_rd_e       = x.mem_rd_e;
      hz.branch_taken_e = x.br;
      hz.mc_op_d        = x.mc_op_d;
      hz.mc_start_e     = x.mc_start;
      hz.mc_done        = x.mc_done;
      q.push_back(model_out(x));
      @(posedge clk);
      model_next(x);
      cyc++;
      #1;
   endtask

   task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0b expected %0b",
                  nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("forward_a", hz.forward_a, e.fa);
         chk("forward_b", hz.forward_b, e.fb);
         chk("stall_f", {1'b0, hz.stall_f}, {1'b0, e.sf});
         chk("stall_d", {1'b0, hz.stall_d}, {1'b0, e.sd});
         chk("stall_e", {1'b0, hz.stall_e}, {1'b0, e.se});
         chk("flush_d", {1'b0, hz.flush_d}, {1'b0, e.fd});
         chk("flush_e", {1'b0, hz.flush_e}, {1'b0, e.fe});
         chk("mc_timeout", {1'b0, hz.mc_timeout}, {1'b0, e.tmo});
      end
   end

   initial begin
      stim_t x;
      x = '0;
      x.rst = 1'b1;
      hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
      hz.rd_e = '0; hz.rd_m = '0; hz.rd_w = '0; hz.mc_rd = '0;
      hz.reg_wr_m = 0; hz.reg_wr_w = 0; hz.mem_rd_e = 0;
      hz.branch_taken_e = 0; hz.mc_op_d = 0;
      hz.mc_start_e = 0; hz.mc_done = 0;
      @(posedge clk);
      #1;

      // reset holds every output low
      for (int i = 0; i < 3; i++) begin
         x = rnd(); x.rst = 1'b1; step(x);
      end
      x = '0; step(x);

      // forwarding: M over W, x0 never forwarded
      x = '0;
      x.rs1_e = 5'd7; x.rs2_e = 5'd3;
      x.rd_m = 5'd7; x.reg_wr_m = 1; x.rd_w = 5'd7; x.reg_wr_w = 1;
      step(x);
      x.rs1_e = 5'd0; step(x);
      x.rs2_e = 5'd7; x.reg_wr_m = 0; step(x);

      // lw x5 ; add x6,x5,x1 -> two bubbles, then W forward
      x = '0; x.mem_rd_e = 1; x.rd_e = 5'd5;
      x.rs1_d = 5'd5; x.rs2_d = 5'd1; step(x);
      x = '0; x.rs1_d = 5'd5; x.rs2_d = 5'd1; step(x);
      x = '0; x.rs1_e = 5'd5; x.rs2_e = 5'd1;
      x.rd_w = 5'd5; x.reg_wr_w = 1; step(x);

      // branch in the stall cycle aborts the load bubble
      x = '0; x.mem_rd_e = 1; x.rd_e = 5'd5; x.rs2_d = 5'd5; step(x);
      x = '0; x.br = 1; x.rs2_d = 5'd5; step(x);
      x = '0; step(x);

      // mc op rd=9, done 10 cycles after issue
      x = '0; x.mc_start = 1; x.mc_rd = 5'd9; step(x);
      for (int i = 1; i <= 10; i++) begin
         x = '0;
         x.rs1_d = (i < 6) ? 5'd3 : 5'd9;
         x.mc_done = (i == 10);
         step(x);
      end
      x = '0; x.rs1_d = 5'd9; step(x);

      // watchdog expiry
      x = '0; x.mc_start = 1; x.mc_rd = 5'd4; step(x);
      for (int i = 0; i < 70; i++) begin
         x = '0; step(x);
      end

      // reset while busy clears the sticky flag
      x = '0; x.mc_start = 1; x.mc_rd = 5'd2; step(x);
      x = '0; step(x); step(x);
      x.rst = 1; step(x);
      x = '0; step(x);

      for (int i = 0; i < 3000; i++) step(rnd());

      x = '0; step(x);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, 0 required", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
